// File: rtl/sdes_engine.sv
// Iterative S-DES engine: key schedule, IP, two time-shared fk rounds with SW, IP^-1.
// One block per start/done handshake, result four edges after the accepting edge.

module sdes_fk (
  input  logic [0:7] data,
  input  logic [0:7] subkey,
  output logic [0:7] result
);

  logic [0:7] ep;
  logic [0:7] mixed;
  logic [1:0] s0_val;
  logic [1:0] s1_val;
  logic [0:3] sbox_out;
  logic [0:3] p4;

  function automatic logic [1:0] sbox0(input logic [3:0] idx);
    logic [1:0] v;
    case (idx)
      4'd0:  v = 2'd1;  4'd1:  v = 2'd0;  4'd2:  v = 2'd3;  4'd3:  v = 2'd2;
      4'd4:  v = 2'd3;  4'd5:  v = 2'd2;  4'd6:  v = 2'd1;  4'd7:  v = 2'd0;
      4'd8:  v = 2'd0;  4'd9:  v = 2'd2;  4'd10: v = 2'd1;  4'd11: v = 2'd3;
      4'd12: v = 2'd3;  4'd13: v = 2'd1;  4'd14: v = 2'd3;  default: v = 2'd2;
    endcase
    return v;
  endfunction

  function automatic logic [1:0] sbox1(input logic [3:0] idx);
    logic [1:0] v;
    case (idx)
      4'd0:  v = 2'd0;  4'd1:  v = 2'd1;  4'd2:  v = 2'd2;  4'd3:  v = 2'd3;
      4'd4:  v = 2'd2;  4'd5:  v = 2'd0;  4'd6:  v = 2'd1;  4'd7:  v = 2'd3;
      4'd8:  v = 2'd3;  4'd9:  v = 2'd0;  4'd10: v = 2'd1;  4'd11: v = 2'd0;
      4'd12: v = 2'd2;  4'd13: v = 2'd1;  4'd14: v = 2'd0;  default: v = 2'd3;
    endcase
    return v;
  endfunction

  // S-box row is {outer bits}, column is {inner bits}; index = row*4 + col
  always_comb begin
    ep       = {data[7], data[4], data[5], data[6], data[5], data[6], data[7], data[4]};
    mixed    = ep ^ subkey;
    s0_val   = sbox0({mixed[0], mixed[3], mixed[1], mixed[2]});
    s1_val   = sbox1({mixed[4], mixed[7], mixed[5], mixed[6]});
    sbox_out = {s0_val, s1_val};
    p4       = {sbox_out[1], sbox_out[3], sbox_out[2], sbox_out[0]};
    result   = {data[0:3] ^ p4, data[4:7]};
  end

endmodule

module sdes_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       decrypt,
  input  logic [0:9] key,
  input  logic [0:7] din,
  output logic       busy,
  output logic       done,
  output logic [0:7] dout
);

  // state  | meaning
  // IDLE   | waiting for start; captures IP(din), key, mode
  // KEYGEN | derive K1/K2 from captured key
  // ROUND1 | fk with first subkey, then nibble swap
  // ROUND2 | fk with second subkey, no swap
  // OUTPUT | apply IP^-1 into dout, pulse done
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYGEN = 3'd1,
    ROUND1 = 3'd2,
    ROUND2 = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [0:7] data_r;
  logic [0:9] key_r;
  logic       mode_r;
  logic [0:7] k1_r;
  logic [0:7] k2_r;
  logic [0:7] round_key;
  logic [0:7] fk_out;

  function automatic logic [0:9] p10(input logic [0:9] k);
    return {k[2], k[4], k[1], k[6], k[3], k[9], k[0], k[8], k[7], k[5]};
  endfunction

  function automatic logic [0:9] ls1(input logic [0:9] k);
    return {k[1:4], k[0], k[6:9], k[5]};
  endfunction

  function automatic logic [0:9] ls2(input logic [0:9] k);
    return {k[2:4], k[0:1], k[7:9], k[5:6]};
  endfunction

  function automatic logic [0:7] p8(input logic [0:9] k);
    return {k[5], k[2], k[6], k[3], k[7], k[4], k[9], k[8]};
  endfunction

  function automatic logic [0:7] ip(input logic [0:7] d);
    return {d[1], d[5], d[2], d[0], d[3], d[7], d[4], d[6]};
  endfunction

  function automatic logic [0:7] ip_inv(input logic [0:7] d);
    return {d[3], d[0], d[2], d[4], d[6], d[1], d[7], d[5]};
  endfunction

  // decrypt simply reverses subkey order across the two rounds
  always_comb begin
    round_key = k1_r;
    if (state == ROUND1) round_key = mode_r ? k2_r : k1_r;
    else if (state == ROUND2) round_key = mode_r ? k1_r : k2_r;
  end

  sdes_fk u_fk (
    .data   (data_r),
    .subkey (round_key),
    .result (fk_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = KEYGEN;
      end
      KEYGEN:  next_state = ROUND1;
      ROUND1:  next_state = ROUND2;
      ROUND2:  next_state = OUTPUT;
      OUTPUT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;
      key_r  <= '0;
      mode_r <= 1'b0;
      k1_r   <= '0;
      k2_r   <= '0;
      dout   <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_r <= ip(din);
            key_r  <= key;
            mode_r <= decrypt;
          end
        end
        KEYGEN: begin
          k1_r <= p8(ls1(p10(key_r)));
          k2_r <= p8(ls2(ls1(p10(key_r))));
        end
        ROUND1: data_r <= {fk_out[4:7], fk_out[0:3]};
        ROUND2: data_r <= fk_out;
        OUTPUT: begin
          dout <= ip_inv(data_r);
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_engine.sv
// Directed and random checks of sdes_engine against an independent table-driven S-DES model.

module tb_sdes_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       decrypt = 1'b0;
  logic [0:9] key = '0;
  logic [0:7] din = '0;
  logic       busy;
  logic       done;
  logic [0:7] dout;

  int         total = 0;
  int         bad = 0;
  logic [0:7] exp_q[$];

  localparam int P10_T [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_T  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IP_T  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IPI_T [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP_T  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4_T  [4]  = '{2, 4, 3, 1};
  localparam int S0_T [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  localparam int S1_T [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  sdes_engine dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .decrypt (decrypt),
    .key     (key),
    .din     (din),
    .busy    (busy),
    .done    (done),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [0:9] m_p10(input logic [0:9] k);
    logic [0:9] o;
    for (int i = 0; i < 10; i++) o[i] = k[P10_T[i]-1];
    return o;
  endfunction

  function automatic logic [0:9] m_ls(input logic [0:9] k, input int n);
    logic [0:9] o;
    for (int i = 0; i < 5; i++) begin
      o[i]   = k[(i+n)%5];
      o[5+i] = k[5+(i+n)%5];
    end
    return o;
  endfunction

  function automatic logic [0:7] m_p8(input logic [0:9] k);
    logic [0:7] o;
    for (int i = 0; i < 8; i++) o[i] = k[P8_T[i]-1];
    return o;
  endfunction

  function automatic logic [0:7] m_perm8(input logic [0:7] d, input bit inverse);
    logic [0:7] o;
    for (int i = 0; i < 8; i++) o[i] = inverse ? d[IPI_T[i]-1] : d[IP_T[i]-1];
    return o;
  endfunction

  function automatic logic [0:7] m_fk(input logic [0:7] d, input logic [0:7] sk);
    logic [0:7] e;
    logic [0:3] s;
    logic [0:3] p;
    int         v0, v1;
    for (int i = 0; i < 8; i++) e[i] = d[4+EP_T[i]-1];
    e  = e ^ sk;
    v0 = S0_T[e[0]*2+e[3]][e[1]*2+e[2]];
    v1 = S1_T[e[4]*2+e[7]][e[5]*2+e[6]];
    s  = 4'(v0*4 + v1);
    for (int i = 0; i < 4; i++) p[i] = s[P4_T[i]-1];
    return {d[0:3] ^ p, d[4:7]};
  endfunction

  function automatic logic [0:7] m_sdes(input logic [0:9] k, input logic [0:7] d, input logic dec);
    logic [0:9] s1;
    logic [0:7] k1, k2, x;
    s1 = m_ls(m_p10(k), 1);
    k1 = m_p8(s1);
    k2 = m_p8(m_ls(s1, 2));
    x  = m_perm8(d, 1'b0);
    x  = m_fk(x, dec ? k2 : k1);
    x  = {x[4:7], x[0:3]};
    x  = m_fk(x, dec ? k1 : k2);
    return m_perm8(x, 1'b1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [0:9] k, input logic [0:7] d, input logic dec,
                           input logic [0:7] expv);
    key     = k;
    din     = d;
    decrypt = dec;
    start   = 1'b1;
    exp_q.push_back(expv);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    logic [0:7] held;
    logic [0:7] expv;
    bit         stable;
    int         lat;
    held   = dout;
    stable = 1'b1;
    lat    = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      if (!done && dout !== held) stable = 1'b0;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, " dout_stable"}, 32'(stable), 32'd1);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    chk({tag, " dout"}, 32'(dout), 32'(expv));
  endtask

  initial begin
    logic [0:9] bk [3];
    logic [0:7] bd [3];
    logic [0:7] ct;
    logic [0:9] rk;
    logic [0:7] rd;
    int         ndone, cyc, last_done, accepted;
    logic       prev_busy;

    #12;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset dout", 32'(dout), 32'h00);
    chk("reset k1_r", 32'(dut.k1_r), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    start_txn(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000);
    chk("kat_enc busy_after_accept", 32'(busy), 32'd1);
    wait_done("kat_enc", 4);
    chk("kat_enc k1_r", 32'(dut.k1_r), 32'(8'b10100100));
    chk("kat_enc k2_r", 32'(dut.k2_r), 32'(8'b01000011));

    start_txn(10'b1010000010, 8'b00111000, 1'b1, 8'b10010111);
    wait_done("kat_dec", 4);

    start_txn(10'b1010000010, 8'b10010111, 1'b0, 8'b00111000);
    tick();
    key = 10'h3FF; din = 8'hFF; decrypt = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_ignore", 2);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("busy_ignore extra_done", ndone, 0);

    start_txn(10'b1100110011, 8'hA5, 1'b0, m_sdes(10'b1100110011, 8'hA5, 1'b0));
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort dout", 32'(dout), 32'h00);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort no_done", ndone, 0);

    bk = '{10'h2C5, 10'h01F, 10'h3A0};
    bd = '{8'h3C, 8'hE1, 8'h07};
    for (int i = 0; i < 3; i++) exp_q.push_back(m_sdes(bk[i], bd[i], 1'(i == 1)));
    key = bk[0]; din = bd[0]; decrypt = 1'b0; start = 1'b1;
    prev_busy = busy;
    ndone = 0; cyc = 0; last_done = 0; accepted = 0;
    while (ndone < 3 && cyc < 40) begin
      tick();
      cyc++;
      if (busy && !prev_busy) begin
        accepted++;
        if (accepted < 3) begin
          key = bk[accepted]; din = bd[accepted]; decrypt = 1'(accepted == 1);
        end else start = 1'b0;
      end
      if (done) begin
        chk($sformatf("b2b dout%0d", ndone), 32'(dout), 32'(exp_q.pop_front()));
        if (ndone > 0) chk($sformatf("b2b spacing%0d", ndone), cyc - last_done, 5);
        last_done = cyc;
        ndone++;
      end
      prev_busy = busy;
    end
    start = 1'b0;
    chk("b2b count", ndone, 3);
    exp_q.delete();
    tick();

    for (int n = 0; n < 1000; n++) begin
      rk = 10'($urandom_range(0, 1023));
      rd = 8'($urandom_range(0, 255));
      start_txn(rk, rd, 1'b0, m_sdes(rk, rd, 1'b0));
      wait_done("rand_enc", 4);
      ct = dout;
      start_txn(rk, ct, 1'b1, rd);
      wait_done("rand_dec", 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
